// File: rtl/nios_system_pio_pkg.sv
// nios_system_pio_pkg: shared register offsets and defaults for the nios_system PIO slaves
package nios_system_pio_pkg;
  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_BLINK = 3'd1;
  localparam logic [2:0] ADDR_PERIOD = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;
  localparam int LEDR_WIDTH = 10;
  localparam int BLINK_DIV_DEFAULT = 25000000;
endpackage

// File: rtl/nios_system_ledr_blink_timer.sv
// nios_system_ledr_blink_timer: programmable half-period down-counter producing the blink phase
module nios_system_ledr_blink_timer
  import nios_system_pio_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int BLINK_DIV = BLINK_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             phase,
  output logic             running,
  output logic [CNT_W-1:0] period
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic [CNT_W-1:0] cnt;
  assign running = period != '0;
  // a period load restarts the half-period and wins over a same-cycle expiry
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      period <= CNT_W'(BLINK_DIV);
      cnt <= CNT_W'(BLINK_DIV - 1);
      phase <= 1'b1;
    end else if (load) begin
      period <= load_val;
      cnt <= load_val == '0 ? '0 : load_val - ONE;
      phase <= 1'b1;
    end else if (!running) begin
      cnt <= '0;
      phase <= 1'b1;
    end else if (cnt == '0) begin
      cnt <= period - ONE;
      phase <= ~phase;
    end else
      cnt <= cnt - ONE;
endmodule

// File: rtl/nios_system_ledr_pio.sv
// nios_system_ledr_pio: Avalon-MM LED output PIO with set/clear offsets and per-bit blink
module nios_system_ledr_pio
  import nios_system_pio_pkg::*;
#(
  parameter int WIDTH = LEDR_WIDTH,
  parameter int RESET_VALUE = 0,
  parameter int BLINK_DIV = BLINK_DIV_DEFAULT,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);
  logic wr, phase, running;
  logic [WIDTH-1:0] wd, data_q, data_d, blink_q;
  logic [CNT_W-1:0] period;
  logic [31:0] rd_d;
  assign wr = chipselect & ~write_n;
  assign wd = writedata[WIDTH-1:0];
  nios_system_ledr_blink_timer #(.CNT_W(CNT_W), .BLINK_DIV(BLINK_DIV)) u_timer (
    .clk(clk),
    .reset_n(reset_n),
    .load(wr && address == ADDR_PERIOD),
    .load_val(writedata[CNT_W-1:0]),
    .phase(phase),
    .running(running),
    .period(period)
  );
  always_comb
    data_d = !wr ? data_q :
             address == ADDR_DATA ? wd :
             address == ADDR_OUTSET ? data_q | wd :
             address == ADDR_OUTCLR ? data_q & ~wd : data_q;
  always_comb
    rd_d = address == ADDR_DATA ? 32'(data_q) :
           address == ADDR_BLINK ? 32'(blink_q) :
           address == ADDR_PERIOD ? 32'(period) :
           address == ADDR_STATUS ? {30'd0, running, phase} : 32'd0;
  // readback is free-running so the master sees the word one cycle after presenting the address
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      data_q <= WIDTH'(RESET_VALUE);
      blink_q <= '0;
      readdata <= '0;
      out_port <= WIDTH'(RESET_VALUE);
    end else begin
      data_q <= data_d;
      blink_q <= wr && address == ADDR_BLINK ? wd : blink_q;
      readdata <= rd_d;
      out_port <= data_q & ~(blink_q & {WIDTH{~phase}});
    end
endmodule
